// File: rtl/param_regfile_pkg.sv
// Shared types and helpers for the parametrised register file.
// The optional write-through path is enabled by PARAM_REGFILE_BYPASS_EN.
package param_regfile_pkg;

    typedef logic [0:0] state_t;
    localparam state_t ST_CLEAR = 1'b0;
    localparam state_t ST_READY = 1'b1;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 6;
    localparam int DEPTH_DEF  = 64;

    // True when addr names a real register that may be written or read.
    function automatic logic wr_legal(input logic [31:0] addr,
                                      input logic [31:0] depth,
                                      input logic        zero_reg);
        return (addr < depth) && !(zero_reg && (addr == 32'd0));
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks every address once with a zero write,
// then raises ready and stays there until the next reset.
module regfile_clear_seq
    import param_regfile_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_r;
    logic [ADDR_W-1:0] clr_ptr_r;
    logic              ready_r;

    // Sweep FSM; ready is registered alongside the state so it never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_CLEAR;
            clr_ptr_r <= {ADDR_W{1'b0}};
            ready_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    clr_ptr_r <= clr_ptr_r + ADDR_W'(1);
                    if (clr_ptr_r == LAST_ADDR) begin
                        state_r <= ST_READY;
                        ready_r <= 1'b1;
                    end else begin
                        state_r <= ST_CLEAR;
                        ready_r <= 1'b0;
                    end
                end
                ST_READY: begin
                    state_r <= ST_READY;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r   <= ST_CLEAR;
                    clr_ptr_r <= {ADDR_W{1'b0}};
                    ready_r   <= 1'b0;
                end
            endcase
        end
    end

    // Reset has priority: no memory write happens on a reset cycle.
    assign clr_we   = (state_r == ST_CLEAR) && !rst;
    assign clr_addr = clr_ptr_r;
    assign ready    = ready_r;

endmodule

// File: rtl/param_regfile.sv
// Parametrised register file with registered reads, optional zero register,
// self-clearing after reset and optional write-through (PARAM_REGFILE_BYPASS_EN).
module param_regfile
    import param_regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wrt,
    input  logic [ADDR_W-1:0]          rd,
    input  logic [DATA_W-1:0]          dataIn,
    input  logic [NUM_RD*ADDR_W-1:0]   rs_addr,
    output logic [NUM_RD*DATA_W-1:0]   rs_data,
    output logic                       ready,
    output logic                       wr_err
);

    localparam logic [31:0] DEPTH_U    = 32'(DEPTH);
    localparam logic        ZERO_REG_B = (ZERO_REG != 0);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic              clr_we_s;
    logic [ADDR_W-1:0] clr_addr_s;
    logic              ready_s;
    logic              wr_ok_s;
    logic              wr_err_r;

    regfile_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_we   (clr_we_s),
        .clr_addr (clr_addr_s),
        .ready    (ready_s)
    );

    assign wr_ok_s = wrt && ready_s && !rst && wr_legal(32'(rd), DEPTH_U, ZERO_REG_B);

    // Storage: the clear sweep owns the write port until ready.
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            mem_r[clr_addr_s] <= {DATA_W{1'b0}};
        end else if (wr_ok_s) begin
            mem_r[rd] <= dataIn;
        end
    end

    // Sticky error: any write during the sweep or to a nonexistent register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err_r <= 1'b0;
        end else if (wrt && (!ready_s || (32'(rd) >= DEPTH_U))) begin
            wr_err_r <= 1'b1;
        end else begin
            wr_err_r <= wr_err_r;
        end
    end

    assign wr_err = wr_err_r;
    assign ready  = ready_s;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr_s;
        logic [DATA_W-1:0] next_s;
        logic [DATA_W-1:0] data_r;

        assign addr_s = rs_addr[i*ADDR_W +: ADDR_W];

        // Read mux: zero while clearing or for illegal addresses.
        always_comb begin
            next_s = {DATA_W{1'b0}};
            if (!ready_s || !wr_legal(32'(addr_s), DEPTH_U, ZERO_REG_B)) begin
                next_s = {DATA_W{1'b0}};
            end else begin
`ifdef PARAM_REGFILE_BYPASS_EN
                if (wr_ok_s && (addr_s == rd)) begin
                    next_s = dataIn;
                end else begin
                    next_s = mem_r[addr_s];
                end
`else
                next_s = mem_r[addr_s];
`endif
            end
        end

        // Registered read data.
        always_ff @(posedge clk) begin
            if (rst) begin
                data_r <= {DATA_W{1'b0}};
            end else begin
                data_r <= next_s;
            end
        end

        assign rs_data[i*DATA_W +: DATA_W] = data_r;
    end

endmodule

// File: tb/tb_param_regfile.sv
// Scoreboard bench for param_regfile: a spec-level model predicts each edge's
// outputs, a separate monitor compares them on the falling edge.
module tb_param_regfile;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 48;
    localparam int NUM_RD = 2;
`ifdef PARAM_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     wrt;
    logic [ADDR_W-1:0]        rd;
    logic [DATA_W-1:0]        dataIn;
    logic [NUM_RD*ADDR_W-1:0] rs_addr;
    logic [NUM_RD*DATA_W-1:0] rs_data;
    logic                     ready;
    logic                     wr_err;

    param_regfile #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wrt     (wrt),
        .rd      (rd),
        .dataIn  (dataIn),
        .rs_addr (rs_addr),
        .rs_data (rs_data),
        .ready   (ready),
        .wr_err  (wr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_RD*DATA_W-1:0] rs;
        logic                     rdy;
        logic                     err;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: register contents, edges since reset, sticky error.
    logic [DATA_W-1:0] m_mem [DEPTH];
    int                m_cnt;
    bit                m_err;

    task automatic step(input bit r, input bit w, input int unsigned a_wr,
                        input logic [DATA_W-1:0] d,
                        input int unsigned a0, input int unsigned a1);
        exp_t e;
        bit   usable;
        bit   legal;
        int unsigned a;
        rst     = r;
        wrt     = w;
        rd      = ADDR_W'(a_wr);
        dataIn  = d;
        rs_addr = {ADDR_W'(a1), ADDR_W'(a0)};
        e.rs = '0;
        if (r) begin
            m_cnt = 0;
            m_err = 1'b0;
        end else begin
            usable = (m_cnt >= DEPTH);
            legal  = usable && w && (a_wr < DEPTH) && (a_wr != 0);
            for (int p = 0; p < NUM_RD; p++) begin
                a = (p == 0) ? a0 : a1;
                if (usable && (a < DEPTH) && (a != 0))
                    e.rs[p*DATA_W +: DATA_W] = (BYP && legal && a == a_wr) ? d : m_mem[a];
            end
            if (w && (!usable || a_wr >= DEPTH)) m_err = 1'b1;
            if (legal) m_mem[a_wr] = d;
            if (!usable) begin
                m_cnt++;
                if (m_cnt == DEPTH) foreach (m_mem[i]) m_mem[i] = '0;
            end
        end
        e.rdy = (m_cnt >= DEPTH);
        e.err = m_err;
        @(posedge clk);
        sb_q.push_back(e);
        #1;
    endtask

    // Monitor: one expectation per edge, compared on the following falling edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks += 3;
                if (rs_data !== e.rs) begin
                    errors++;
                    $display("FAIL rs_data t=%0t got=%h exp=%h", $time, rs_data, e.rs);
                end
                if (ready !== e.rdy) begin
                    errors++;
                    $display("FAIL ready t=%0t got=%b exp=%b", $time, ready, e.rdy);
                end
                if (wr_err !== e.err) begin
                    errors++;
                    $display("FAIL wr_err t=%0t got=%b exp=%b", $time, wr_err, e.err);
                end
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1; wrt = 1'b0; rd = '0; dataIn = '0; rs_addr = '0;
        foreach (m_mem[i]) m_mem[i] = '0;
        m_cnt = 0;
        m_err = 1'b0;

        repeat (3) step(1'b1, 1'b0, 0, 32'h0, 0, 0);
        // Partial sweep with an illegal write, then a reset mid-sweep.
        for (int i = 0; i < 20; i++) step(1'b0, i == 10, 3, 32'hAB, i, i + 1);
        step(1'b1, 1'b0, 0, 32'h0, 0, 0);
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, i == 5, 3, 32'hAB, i % 64, 63 - i);
        for (int i = 0; i < 64; i++) step(1'b0, 1'b0, 0, 32'h0, i, 63 - i);

        // Clean sweep, then directed cases.
        step(1'b1, 1'b0, 0, 32'h0, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 0, 32'h0, 5, 7);
        step(1'b0, 1'b1, 5, 32'hDEADBEEF, 0, 0);
        step(1'b0, 1'b0, 0, 32'h0, 5, 5);
        step(1'b0, 1'b1, 7, 32'h11, 0, 0);
        step(1'b0, 1'b1, 7, 32'h22, 7, 7);
        step(1'b0, 1'b0, 0, 32'h0, 7, 7);
        step(1'b0, 1'b1, 0, 32'h55, 0, 0);
        step(1'b0, 1'b0, 0, 32'h0, 0, 5);
        step(1'b0, 1'b1, 50, 32'h99, 0, 0);
        step(1'b0, 1'b0, 0, 32'h0, 50, 50);
        step(1'b0, 1'b0, 0, 32'h0, 47, 5);

        // Random traffic with occasional resets; small address range forces collisions.
        for (int n = 0; n < 600; n++) begin
            int unsigned wa, ra0, ra1;
            wa  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 11);
            ra0 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 11);
            ra1 = $urandom_range(0, 1) ? ra0 : $urandom_range(0, 11);
            step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, wa, $urandom, ra0, ra1);
        end

        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/param_regfile.md
Name: param_regfile

Overview:
- Parametrised successor to the datapath register file: configurable width, depth and read-port count.
- Registered (synchronous) reads and optional hardwired-zero register 0.
- Built-in clear sequencer wipes every entry after reset; a `ready` flag reports when the file is usable.
- Sits between decode (addresses) and ALU/writeback (operands, result).

Parameters:
- DATA_W, 32, width of each register in bits.
- ADDR_W, 6, address width.
- DEPTH, 64, number of registers; must satisfy 2 <= DEPTH <= 2**ADDR_W.
- NUM_RD, 2, number of read ports; must satisfy 1..4.
- ZERO_REG, 1, if 1 then register 0 always reads 0 and writes to it are discarded.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset. Synchronous, active-high, single clock domain (clk).
- wrt  input  1  write enable.
- rd  input  ADDR_W  write address.
- dataIn  input  DATA_W  write data.
- rs_addr  input  NUM_RD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- rs_data  output  NUM_RD*DATA_W  packed registered read data, port i at [i*DATA_W +: DATA_W].
- ready  output  1  high once the clear sweep is complete.
- wr_err  output  1  sticky error flag; set by illegal writes, cleared only by rst.

Behaviour:
- Reset values: rs_data=0, ready=0, wr_err=0. The FSM enters CLEAR with clr_ptr=0.
- FSM has two states, CLEAR and READY.
  - rst=1 in any state, at any time: next state CLEAR, clr_ptr=0, rs_data=0, wr_err=0. Memory is untouched during that cycle.
  - CLEAR with rst=0: writes 0 to mem[clr_ptr]; clr_ptr increments.
  - When clr_ptr==DEPTH-1, the next state is READY.
  - ready rises on the DEPTH-th rising edge after rst falls.
  - READY: stays in READY until the next rst.
- Reset asserted mid-sweep restarts the sweep at address 0. No partial-ready pulse is allowed.
- While in CLEAR:
  - rs_data is held at 0.
  - User writes are dropped.
  - wrt=1 sets wr_err.
- Write, in READY:
  - On a rising edge with wrt=1 and rd<DEPTH, mem[rd] <= dataIn.
  - rd>=DEPTH: write dropped, wr_err set.
  - ZERO_REG=1 and rd==0: write dropped silently; wr_err is not set.
- Read, in READY:
  - Each port samples its rs_addr on a rising edge; rs_data updates on that same edge. Latency is 1 cycle.
  - Out-of-range address (>=DEPTH) returns 0.
  - ZERO_REG=1 and address 0 returns 0.
- Same-edge read and write to the same address: read-before-write, i.e. the old value is returned, unless the bypass feature is compiled in.
- Multiple read ports addressing the same register all return the same value.
- No delays inside always blocks. Use nonblocking assignments only.

Optional Feature:
- Macro: PARAM_REGFILE_BYPASS_EN.
- Defined: write-through forwarding. When wrt=1, the write is legal, and rs_addr[i]==rd in READY, port i returns dataIn on that edge. Forwarding is never applied to a dropped write (ZERO_REG, out-of-range, CLEAR).
- Undefined: read-before-write as described above.

Decomposition:
- Package param_regfile_pkg holds:
  - the state typedef (CLEAR, READY);
  - default constants DATA_W_DEF=32, ADDR_W_DEF=6, DEPTH_DEF=64;
  - a function checking a legal user write (in range, not zero-reg).
- One sub-module, regfile_clear_seq, holds the FSM and clr_ptr.
  - Inputs: clk, rst.
  - Outputs: clr_we, clr_addr, ready.
- The top level muxes clr_we/clr_addr against the user write and generates the NUM_RD read ports.

Test Plan:
- Reset sweep: assert rst for 3 cycles, then release → ready=0 for 63 edges and ready=1 on the 64th; every register reads 0.
- Basic write/read: write 0xDEADBEEF to reg 5, next cycle set rs_addr port0=5 and port1=5 → both ports show 0xDEADBEEF one edge later.
- Same-edge collision: reg 7=0x11, then write 0x22 to reg 7 while reading 7 on the same edge.
  - Without macro: 0x11.
  - With PARAM_REGFILE_BYPASS_EN: 0x22.
  - Following cycle: 0x22 in both builds.
- Zero register and range (ZERO_REG=1, DEPTH=48):
  - Write 0x55 to reg 0 → reads 0, wr_err stays 0.
  - Write to reg 50 → dropped, wr_err=1, read of 50 returns 0.
- Reset mid-sweep: pulse rst 20 cycles into the sweep → ready stays 0 until 64 edges after the second release; wr_err cleared.
- Write during CLEAR: wrt=1, rd=3, dataIn=0xAB while ready=0 → wr_err=1; reg 3 reads 0 after ready.
